jt7759_seq: RTL and testbench
=============================

JT7759_SEQ -- requirements
Module: jt7759_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. Clock port: clk. Reset port: rst.
REQ-002 SHALL have these ports:
- rst  in  1  synchronous active-high reset
- clk  in  1  system clock
- cen4  in  1  one-cycle strobe, 160 kHz
- cendec  in  1  decoder-rate strobe from the rate divider
- start  in  1  one-cycle request to play phrase
- phrase  in  8  phrase number, sampled on start
- busy  out  1  high from accepted start until phrase end
- rom_cs  out  1  ROM read request, held until rom_ok
- rom_addr  out  17  ROM byte address
- rom_data  in  8  ROM read data, valid with rom_ok
- rom_ok  in  1  ROM data valid, at least 1 cycle after rom_cs
- divby  out  6  rate setting for the divider
- dec_rst  out  1  holds the ADPCM decoder in reset
- nibble  out  4  ADPCM nibble
- nib_ok  out  1  one-cycle pulse, nibble valid
- done  out  1  one-cycle pulse at phrase end

Function
REQ-003 SHALL have these FSM states: IDLE, PTR_HI, PTR_LO, CMD, LEN, PLAY, SILENCE, END.
REQ-004 IDLE: when start=1, SHALL latch phrase, set busy=1 and go to PTR_HI. While busy=1, start SHALL be ignored.
REQ-005 PTR_HI and PTR_LO SHALL each read the pointer table:
- PTR_HI reads address {phrase,1'b0}; PTR_LO reads that address +1.
- The pointer is {1'b0, hi, lo}, with the MSB zero-extended.
- The pointer becomes the command address and the loop mark.
REQ-006 Every ROM access SHALL follow this handshake:
- Drive rom_cs=1 and a stable rom_addr.
- Capture rom_data in the cycle rom_ok=1.
- Drop rom_cs the next cycle.
- Never have more than one read outstanding.
REQ-007 CMD SHALL fetch one byte at the command address, post-increment the address, and decode it:
- 8'h00: go to END.
- 00nnnnnn with n≠0: go to SILENCE for n×16 cen4 strobes.
- 01dddddd: set divby=d; play 256 nibbles.
- 10dddddd: set divby=d; go to LEN; the next byte L gives L+1 nibbles.
- 11xxxrrr: repeat (see REQ-018).
REQ-008 PLAY SHALL emit nibbles from the byte stream:
- High nibble first, then low nibble.
- A new byte is fetched after the low nibble is consumed, prefetched before the next cendec.
REQ-009 On each cendec in PLAY with a byte ready, SHALL drive nibble and pulse nib_ok the same cycle, then decrement the nibble count.
REQ-010 On a cendec in PLAY with no byte ready (ROM too slow), SHALL skip that tick:
- No nib_ok pulse.
- The count does not change.
REQ-011 When the count reaches 0, SHALL return to CMD. If the block had an odd nibble count, the unused low nibble is discarded.
REQ-012 dec_rst SHALL be 1 in IDLE, PTR_HI, PTR_LO and SILENCE, and 0 otherwise.
REQ-013 SILENCE SHALL count cen4 strobes only. A count of 16 SHALL mean exactly 16 strobes, after which the FSM returns to CMD.
REQ-014 END SHALL take one cycle:
- Pulse done=1.
- busy goes to 0 on the following cycle.
- Go to IDLE.
REQ-015 rom_addr SHALL wrap modulo 2^17 with no error flag.

Reset
REQ-016 On rst=1, SHALL go to IDLE, including mid-read or mid-play. The ROM handshake is abandoned, and a late rom_ok is ignored.
REQ-017 Reset values SHALL be:
- busy=0, rom_cs=0, rom_addr=0
- divby=6'd0, dec_rst=1
- nibble=0, nib_ok=0, done=0
- all counters 0

Configuration
REQ-018 Macro JT7759_REPEAT_EN SHALL control the repeat command.
- With the macro defined, command 11xxxrrr jumps the command address back to the loop mark r+1 times, then continues after the repeat byte. Repeats do not nest.
- With the macro undefined, command 11xxxxxx behaves as 8'h00 (END).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Phrase 3; pointer table at 6/7 = 8'h01/8'h00; commands 8'h45, then 128 data bytes, then 8'h00. Required: divby=5; 256 nib_ok pulses, high nibble first, each coinciding with cendec; then a done pulse; busy=0.
- Command 8'h82, then L=8'h02. Required: exactly 3 nibbles, then the FSM fetches the next command.
- Command 8'h01. Required: dec_rst=1 for exactly 16 cen4 strobes, with no nib_ok.
- rom_ok delayed 40 cycles with divby=0. Required: skipped ticks produce no nib_ok, and the nibble sequence is unchanged.
- rst asserted during PLAY with rom_cs=1. Required: all outputs at reset values the next cycle; a later stray rom_ok has no effect.
- Command 8'hC1 after one play block. Required, with JT7759_REPEAT_EN defined: the block plays 3 times in total. Required, with it undefined: done immediately after the first play.

Source files
------------

// File: rtl/jt7759_seq.sv
// Phrase sequencer for a uPD7759-style ADPCM player: walks the pointer table and command stream, feeds nibbles to the decoder.
// Define JT7759_REPEAT_EN to enable the 11xxxrrr repeat command; otherwise it ends the phrase like 8'h00.
module jt7759_seq (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen4,
    input  logic        cendec,
    input  logic        start,
    input  logic [7:0]  phrase,
    output logic        busy,
    output logic        rom_cs,
    output logic [16:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic [5:0]  divby,
    output logic        dec_rst,
    output logic [3:0]  nibble,
    output logic        nib_ok,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, PTR_HI, PTR_LO, CMD, LEN, PLAY, SILENCE, END
    } state_t;

    state_t      state, nxt;
    logic [7:0]  ptr_hi;
    logic [7:0]  data_buf;
    logic        buf_ok;
    logic        low_half;
    logic [8:0]  nib_cnt;
    logic [9:0]  sil_cnt;
    logic        rd_done;
    logic        tick;
    logic        fetch_req;
`ifdef JT7759_REPEAT_EN
    logic [16:0] mark;
    logic        rep_act;
    logic [2:0]  rep_cnt;
`endif

    assign rd_done   = rom_cs & rom_ok;
    assign tick      = (state == PLAY) & cendec & buf_ok;
    assign fetch_req = (state == PTR_HI) | (state == PTR_LO) | (state == CMD) |
                       (state == LEN) | ((state == PLAY) & ~buf_ok);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt     = state;
        busy    = (state != IDLE);
        done    = (state == END);
        dec_rst = (state == IDLE) | (state == PTR_HI) | (state == PTR_LO) | (state == SILENCE);
        nib_ok  = tick;
        nibble  = 4'd0;
        if (tick) nibble = low_half ? data_buf[3:0] : data_buf[7:4];
        case (state)
            IDLE:    if (start) nxt = PTR_HI;
            PTR_HI:  if (rd_done) nxt = PTR_LO;
            PTR_LO:  if (rd_done) nxt = CMD;
            CMD: begin
                if (rd_done) begin
                    case (rom_data[7:6])
                        2'b00:   nxt = (rom_data[5:0] == 6'd0) ? END : SILENCE;
                        2'b01:   nxt = PLAY;
                        2'b10:   nxt = LEN;
`ifdef JT7759_REPEAT_EN
                        default: nxt = CMD;
`else
                        default: nxt = END;
`endif
                    endcase
                end
            end
            LEN:     if (rd_done) nxt = PLAY;
            PLAY:    if (tick && nib_cnt == 9'd1) nxt = CMD;
            SILENCE: if (cen4 && sil_cnt <= 10'd1) nxt = CMD;
            END:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // One read in flight at most: rom_cs rises only when idle and drops right after rom_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_cs   <= 1'b0;
            rom_addr <= 17'd0;
            divby    <= 6'd0;
            ptr_hi   <= 8'd0;
            data_buf <= 8'd0;
            buf_ok   <= 1'b0;
            low_half <= 1'b0;
            nib_cnt  <= 9'd0;
            sil_cnt  <= 10'd0;
`ifdef JT7759_REPEAT_EN
            mark     <= 17'd0;
            rep_act  <= 1'b0;
            rep_cnt  <= 3'd0;
`endif
        end else begin
            if (rd_done)                 rom_cs <= 1'b0;
            else if (fetch_req && !rom_cs) rom_cs <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr <= {8'd0, phrase, 1'b0};
`ifdef JT7759_REPEAT_EN
                        rep_act  <= 1'b0;
                        rep_cnt  <= 3'd0;
`endif
                    end
                end
                PTR_HI: begin
                    if (rd_done) begin
                        ptr_hi   <= rom_data;
                        rom_addr <= rom_addr + 17'd1;
                    end
                end
                PTR_LO: begin
                    if (rd_done) begin
                        rom_addr <= {1'b0, ptr_hi, rom_data};
`ifdef JT7759_REPEAT_EN
                        mark     <= {1'b0, ptr_hi, rom_data};
`endif
                    end
                end
                CMD: begin
                    if (rd_done) begin
                        rom_addr <= rom_addr + 17'd1;
                        buf_ok   <= 1'b0;
                        low_half <= 1'b0;
                        case (rom_data[7:6])
                            2'b00: sil_cnt <= {rom_data[5:0], 4'd0};
                            2'b01: begin
                                divby   <= rom_data[5:0];
                                nib_cnt <= 9'd256;
                            end
                            2'b10: divby <= rom_data[5:0];
`ifdef JT7759_REPEAT_EN
                            2'b11: begin
                                if (rep_act && rep_cnt == 3'd0) begin
                                    rep_act <= 1'b0;
                                end else begin
                                    rom_addr <= mark;
                                    rep_act  <= 1'b1;
                                    rep_cnt  <= rep_act ? rep_cnt - 3'd1 : rom_data[2:0];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                LEN: begin
                    if (rd_done) begin
                        rom_addr <= rom_addr + 17'd1;
                        nib_cnt  <= {1'b0, rom_data} + 9'd1;
                    end
                end
                PLAY: begin
                    if (rd_done) begin
                        rom_addr <= rom_addr + 17'd1;
                        data_buf <= rom_data;
                        buf_ok   <= 1'b1;
                        low_half <= 1'b0;
                    end
                    // A leftover low nibble of an odd-length block is dropped with the byte.
                    if (tick) begin
                        nib_cnt <= nib_cnt - 9'd1;
                        if (low_half || nib_cnt == 9'd1) buf_ok   <= 1'b0;
                        else                             low_half <= 1'b1;
                    end
                end
                SILENCE: begin
                    if (cen4 && sil_cnt != 10'd0) sil_cnt <= sil_cnt - 10'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt7759_seq.sv
// Directed bench for jt7759_seq: ROM model with programmable latency, strobe generators, nibble monitor.
// Expected repeat behaviour follows JT7759_REPEAT_EN.
module tb_jt7759_seq;

    logic        clk = 1'b0;
    logic        rst, cen4, cendec, start;
    logic [7:0]  phrase, rom_data;
    logic        busy, rom_cs, rom_ok, dec_rst, nib_ok, done;
    logic [16:0] rom_addr;
    logic [5:0]  divby;
    logic [3:0]  nibble;

    int checks = 0;
    int failures = 0;
    int dec_period = 6;
    int rom_lat = 1;
    bit force_ok = 1'b0;
    int misalign = 0;
    logic [7:0] rom [0:131071];
    logic [3:0] nib_q[$];
    logic [3:0] exp_q[$];

    localparam logic [31:0] RST_VEC = {1'b0, 1'b0, 17'd0, 6'd0, 1'b1, 4'd0, 1'b0, 1'b0};

    jt7759_seq dut (
        .rst(rst), .clk(clk), .cen4(cen4), .cendec(cendec),
        .start(start), .phrase(phrase), .busy(busy),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .divby(divby), .dec_rst(dec_rst), .nibble(nibble), .nib_ok(nib_ok), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        int c4 = 0;
        int cd = 0;
        cen4 = 1'b0;
        cendec = 1'b0;
        forever begin
            @(posedge clk); #1;
            c4 = (c4 + 1) % 4;
            cd = (cd + 1) % dec_period;
            cen4 = (c4 == 0);
            cendec = (cd == 0);
        end
    end

    initial begin
        int wait_cnt = 0;
        rom_ok = 1'b0;
        rom_data = 8'd0;
        forever begin
            @(negedge clk);
            rom_ok = force_ok;
            if (rom_cs && !force_ok) begin
                wait_cnt++;
                if (wait_cnt >= rom_lat) begin
                    rom_ok = 1'b1;
                    rom_data = rom[rom_addr];
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (nib_ok) begin
            nib_q.push_back(nibble);
            if (!cendec) misalign++;
        end
    end

    function automatic int first_diff();
        if (nib_q.size() != exp_q.size()) return (nib_q.size() < exp_q.size()) ? nib_q.size() : exp_q.size();
        for (int i = 0; i < nib_q.size(); i++)
            if (nib_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 8'hFF);
    endfunction

    task automatic pulse_start(input logic [7:0] p);
        @(negedge clk);
        phrase = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic load_rom();
        for (int i = 0; i < 131072; i++) rom[i] = 8'h00;
        rom[6] = 8'h01; rom[7] = 8'h00;
        rom[8] = 8'h02; rom[9] = 8'h00;
        rom[10] = 8'h03; rom[11] = 8'h00;
        rom[12] = 8'h04; rom[13] = 8'h00;
        rom[14] = 8'h05; rom[15] = 8'h00;
        rom['h100] = 8'h45;
        for (int i = 0; i < 128; i++) rom['h101 + i] = pat(i);
        rom['h181] = 8'h00;
        rom['h200] = 8'h82; rom['h201] = 8'h02; rom['h202] = 8'hAB; rom['h203] = 8'hCD;
        rom['h204] = 8'h87; rom['h205] = 8'h00; rom['h206] = 8'hE7; rom['h207] = 8'h00;
        rom['h300] = 8'h01; rom['h301] = 8'h00;
        rom['h400] = 8'h80; rom['h401] = 8'h09;
        rom['h402] = 8'h12; rom['h403] = 8'h34; rom['h404] = 8'h56; rom['h405] = 8'h78;
        rom['h406] = 8'h9A; rom['h407] = 8'h00;
        rom['h500] = 8'h80; rom['h501] = 8'h01; rom['h502] = 8'h5A;
        rom['h503] = 8'hC1; rom['h504] = 8'h00;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        start = 1'b0;
        phrase = 8'd0;
        repeat (3) @(negedge clk);
        v = {busy, rom_cs, rom_addr, divby, dec_rst, nibble, nib_ok, done};
        checks++;
        if (v !== RST_VEC) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h want=%h", v, RST_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_play_256();
        bit seen;
        int d;
        nib_q.delete();
        exp_q.delete();
        misalign = 0;
        for (int i = 0; i < 128; i++) begin
            logic [7:0] b;
            b = pat(i);
            exp_q.push_back(b[7:4]);
            exp_q.push_back(b[3:0]);
        end
        pulse_start(8'd3);
        wait_done(6000, seen);
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL play256_done got=0 want=1"); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL play256_busy_at_done got=%b want=1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL play256_busy_after got=%b want=0", busy); end
        checks++;
        if (divby !== 6'd5) begin failures++; $display("[TB] FAIL play256_divby got=%0d want=5", divby); end
        checks++;
        if (nib_q.size() != 256) begin failures++; $display("[TB] FAIL play256_count got=%0d want=256", nib_q.size()); end
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("[TB] FAIL play256_seq first_diff_index=%0d got=%0d entries want=%0d entries", d, nib_q.size(), exp_q.size());
        end
        checks++;
        if (misalign != 0) begin failures++; $display("[TB] FAIL play256_align got=%0d want=0", misalign); end
    endtask

    task automatic test_len_odd();
        bit seen;
        int d;
        nib_q.delete();
        exp_q = '{4'hA, 4'hB, 4'hC, 4'hE};
        pulse_start(8'd4);
        wait_done(2000, seen);
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL len_done got=0 want=1"); end
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("[TB] FAIL len_seq first_diff_index=%0d got=%0d nibbles want=4", d, nib_q.size());
        end
        checks++;
        if (divby !== 6'd7) begin failures++; $display("[TB] FAIL len_divby got=%0d want=7", divby); end
        @(negedge clk);
    endtask

    task automatic test_silence();
        bit seen, f1, f2;
        int cnt, i;
        nib_q.delete();
        pulse_start(8'd5);
        f1 = 1'b0;
        for (int k = 0; k < 300 && !f1; k++) begin @(negedge clk); if (!dec_rst) f1 = 1'b1; end
        f2 = 1'b0;
        for (int k = 0; k < 300 && !f2 && f1; k++) begin @(negedge clk); if (dec_rst) f2 = 1'b1; end
        checks++;
        if (!(f1 && f2)) begin failures++; $display("[TB] FAIL silence_entry got=%b%b want=11", f1, f2); end
        cnt = 0;
        i = 0;
        while (dec_rst && f2 && i < 1000) begin
            if (cen4) cnt++;
            if (i == 5) begin phrase = 8'd3; start = 1'b1; end
            @(negedge clk);
            start = 1'b0;
            i++;
        end
        checks++;
        if (cnt != 16) begin failures++; $display("[TB] FAIL silence_cen4 got=%0d want=16", cnt); end
        wait_done(500, seen);
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL silence_done got=0 want=1"); end
        checks++;
        if (nib_q.size() != 0) begin failures++; $display("[TB] FAIL silence_nibbles got=%0d want=0", nib_q.size()); end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL silence_start_ignored busy got=%b want=0", busy); end
    endtask

    task automatic test_slow_rom();
        bit seen;
        int d;
        nib_q.delete();
        exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        misalign = 0;
        rom_lat = 40;
        pulse_start(8'd6);
        wait_done(3000, seen);
        rom_lat = 1;
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL slow_done got=0 want=1"); end
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("[TB] FAIL slow_seq first_diff_index=%0d got=%0d nibbles want=10", d, nib_q.size());
        end
        checks++;
        if (misalign != 0) begin failures++; $display("[TB] FAIL slow_align got=%0d want=0", misalign); end
        checks++;
        if (divby !== 6'd0) begin failures++; $display("[TB] FAIL slow_divby got=%0d want=0", divby); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_play();
        bit found;
        int n;
        logic [31:0] v;
        nib_q.delete();
        rom_lat = 40;
        pulse_start(8'd3);
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            @(negedge clk);
            if (nib_q.size() >= 2 && rom_cs) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("[TB] FAIL midrst_setup got=0 want=1"); end
        rst = 1'b1;
        @(negedge clk);
        v = {busy, rom_cs, rom_addr, divby, dec_rst, nibble, nib_ok, done};
        checks++;
        if (v !== RST_VEC) begin failures++; $display("[TB] FAIL midrst_outputs got=%h want=%h", v, RST_VEC); end
        rst = 1'b0;
        n = nib_q.size();
        force_ok = 1'b1;
        repeat (3) @(negedge clk);
        force_ok = 1'b0;
        repeat (2) @(negedge clk);
        v = {busy, rom_cs, rom_addr, divby, dec_rst, nibble, nib_ok, done};
        checks++;
        if (v !== RST_VEC) begin failures++; $display("[TB] FAIL midrst_stray_ok got=%h want=%h", v, RST_VEC); end
        checks++;
        if (nib_q.size() != n) begin failures++; $display("[TB] FAIL midrst_nibbles got=%0d want=%0d", nib_q.size(), n); end
        rom_lat = 1;
    endtask

    task automatic test_repeat();
        bit seen;
        int d;
        nib_q.delete();
`ifdef JT7759_REPEAT_EN
        exp_q = '{4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA};
`else
        exp_q = '{4'h5, 4'hA};
`endif
        pulse_start(8'd7);
        wait_done(2000, seen);
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL repeat_done got=0 want=1"); end
        d = first_diff();
        checks++;
        if (d != -1) begin
            failures++;
            $display("[TB] FAIL repeat_seq first_diff_index=%0d got=%0d nibbles want=%0d", d, nib_q.size(), exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        load_rom();
        test_reset();
        test_play_256();
        test_len_odd();
        test_silence();
        test_slow_rom();
        test_reset_mid_play();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
